// File: rtl/rotate_engine_if.sv
// rotate_engine_if: groups the job-control and memory signals of rotate_engine.
//
// Handshake: the engine accepts a job when ready=1 and start=1 on a rising clk
// edge; base/len/amount/incr/dir are captured on that same edge. Completion is
// signalled by a single-cycle done pulse. abort cancels a running job. The
// memory side is a synchronous-read port: mem_rdata is valid the cycle after
// mem_addr is presented, and a write happens on the edge that ends a cycle
// with mem_we=1. dbg_state mirrors the engine FSM state encoding.
interface rotate_engine_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(WIDTH);

  logic             start;
  logic             abort;
  logic [AW-1:0]    base;
  logic [AW:0]      len;
  logic [SW-1:0]    amount;
  logic [SW-1:0]    incr;
  logic             dir;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_rdata;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_we;
  logic             ready;
  logic             done;
  logic [2:0]       dbg_state;

  // Environment side: issues jobs and models the memory.
  modport master (
    output start, abort, base, len, amount, incr, dir, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, ready, done, dbg_state
  );

  // Engine side.
  modport slave (
    input  start, abort, base, len, amount, incr, dir, mem_rdata,
    output mem_addr, mem_wdata, mem_we, ready, done, dbg_state
  );
endinterface

// File: rtl/rotate_engine.sv
// rotate_engine: walks len words of an attached memory starting at base
// (wrapping modulo DEPTH), rotating word k by (amount + k*incr) mod WIDTH in
// direction dir and writing it back in place.
//
// Optional feature macro: ROTATE_ENGINE_BARREL_EN
//   defined   : LOAD captures the word already rotated by a single-cycle
//               barrel rotator; ROTATE is never entered (4 cycles per word).
//   undefined : serial rotation, one bit per cycle in ROTATE (r+4 cycles/word).
// Memory results are the same in both builds.
module rotate_engine #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          reset,
  rotate_engine_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_ROTATE = 3'd3,
    S_WRITE  = 3'd4,
    S_NEXT   = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [AW-1:0]    r_base;
  logic [AW:0]      r_len;
  logic [AW:0]      r_i;
  logic [SW-1:0]    r_acc;
  logic [SW-1:0]    r_incr;
  logic [SW-1:0]    r_cnt;
  logic             r_dir;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_wdata;
  logic [AW-1:0]    r_addr;
  logic             r_done;

  logic [AW:0]      w_i_inc;
  logic [WIDTH-1:0] w_rot_step;
  logic [WIDTH-1:0] w_load_data;
  logic [WIDTH-1:0] w_data_next;
  logic             w_start_job;
  logic             w_start_empty;
  logic             w_last_word;
  logic             w_done_set;
  logic             w_wr_load;

`ifdef ROTATE_ENGINE_BARREL_EN
  // Rotate x by n positions; the doubled word makes wrap-around a plain shift.
  function automatic logic [WIDTH-1:0] f_rotate(
    input logic [WIDTH-1:0] x,
    input logic [SW-1:0]    n,
    input logic             right
  );
    logic [2*WIDTH-1:0] w_dbl;
    logic [2*WIDTH-1:0] w_sh;
    w_dbl = {x, x};
    if (right) begin
      w_sh = w_dbl >> n;
      return w_sh[WIDTH-1:0];
    end else begin
      w_sh = w_dbl << n;
      return w_sh[2*WIDTH-1:WIDTH];
    end
  endfunction
`endif

  // Job-level decodes shared by the FSM and the datapath.
  always_comb begin
    w_start_job   = (r_state == S_IDLE) && bus.start && (bus.len != '0);
    w_start_empty = (r_state == S_IDLE) && bus.start && (bus.len == '0);
    w_i_inc       = r_i + (AW+1)'(1);
    w_last_word   = (w_i_inc == r_len);
    w_done_set    = w_start_empty ||
                    ((r_state == S_NEXT) && w_last_word && !bus.abort);
  end

  // One-bit rotation step and the word captured in LOAD.
  always_comb begin
    w_rot_step = r_dir ? {r_data[0], r_data[WIDTH-1:1]}
                       : {r_data[WIDTH-2:0], r_data[WIDTH-1]};
`ifdef ROTATE_ENGINE_BARREL_EN
    w_load_data = f_rotate(bus.mem_rdata, r_acc, r_dir);
`else
    w_load_data = bus.mem_rdata;
`endif
  end

  // Value the data register takes at the next edge; also feeds write data.
  always_comb begin
    w_data_next = r_data;
    case (r_state)
      S_LOAD:   w_data_next = w_load_data;
      S_ROTATE: w_data_next = w_rot_step;
      default:  w_data_next = r_data;
    endcase
  end

  // Next-state decode; abort overrides everything outside IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_job) w_state_next = S_FETCH;
      end
      S_FETCH: w_state_next = S_LOAD;
      S_LOAD: begin
`ifdef ROTATE_ENGINE_BARREL_EN
        w_state_next = S_WRITE;
`else
        w_state_next = (r_acc == '0) ? S_WRITE : S_ROTATE;
`endif
      end
      S_ROTATE: begin
        // Counter reaching 0 this cycle means this is the last rotate step.
        if (r_cnt == SW'(1)) w_state_next = S_WRITE;
      end
      S_WRITE: w_state_next = S_NEXT;
      S_NEXT:  w_state_next = w_last_word ? S_IDLE : S_FETCH;
      default: w_state_next = S_IDLE;
    endcase
    if ((r_state != S_IDLE) && bus.abort) w_state_next = S_IDLE;
    w_wr_load = (w_state_next == S_WRITE);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Job parameters, word index, rotation counter and data registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_base  <= '0;
      r_len   <= '0;
      r_i     <= '0;
      r_acc   <= '0;
      r_incr  <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_data  <= '0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_job) begin
            r_base <= bus.base;
            r_len  <= bus.len;
            r_acc  <= bus.amount;
            r_incr <= bus.incr;
            r_dir  <= bus.dir;
            r_i    <= '0;
            r_addr <= bus.base;
          end
        end
        S_LOAD: begin
          r_data <= w_load_data;
          r_cnt  <= r_acc;
        end
        S_ROTATE: begin
          r_data <= w_rot_step;
          r_cnt  <= r_cnt - SW'(1);
        end
        S_NEXT: begin
          // Address is the AW-bit sum, so base+i wraps modulo DEPTH.
          r_i    <= w_i_inc;
          r_acc  <= r_acc + r_incr;
          r_addr <= r_base + w_i_inc[AW-1:0];
        end
        default: ;
      endcase
    end
  end

  // Write data is latched on entry to WRITE so it holds between writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         r_wdata <= '0;
    else if (w_wr_load) r_wdata <= w_data_next;
  end

  // Registered completion pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_done <= 1'b0;
    else        r_done <= w_done_set;
  end

  // Moore outputs decoded from state and registers.
  always_comb begin
    bus.ready     = (r_state == S_IDLE);
    bus.done      = r_done;
    bus.mem_we    = (r_state == S_WRITE);
    bus.mem_addr  = r_addr;
    bus.mem_wdata = r_wdata;
    bus.dbg_state = r_state;
  end
endmodule

// File: tb/tb_rotate_engine.sv
// tb_rotate_engine: directed jobs on an 8-bit x 64-word engine with a
// synchronous-read memory model and a write scoreboard.
module tb_rotate_engine;
  localparam int WIDTH = 8;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int SW    = 3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_ROTATE = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;

  logic clk;
  logic reset;

  rotate_engine_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  rotate_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [WIDTH-1:0] mem [DEPTH];
  logic             pl_en;
  logic [AW-1:0]    pl_addr;
  logic [WIDTH-1:0] pl_data;

  always @(posedge clk) begin
    if (pl_en)           mem[pl_addr] <= pl_data;
    else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  // ---------------- scoreboard ----------------
  logic [AW+WIDTH-1:0] exp_q[$];
  int total;
  int bad;
  int done_cnt;
  int writes_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    exp_q.push_back({a, d});
  endtask

  // Monitor: every write pops one expectation; done pulses are counted.
  initial begin
    logic [AW+WIDTH-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (reset && bus.mem_we) begin
        writes_seen++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr %0d data %0h want none",
                   bus.mem_addr, bus.mem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 32'(bus.mem_addr), 32'(e[AW+WIDTH-1:WIDTH]));
          check("write_data", 32'(bus.mem_wdata), 32'(e[WIDTH-1:0]));
        end
      end
      if (reset && bus.done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    @(negedge clk);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  // Returns at the negedge after the edge that sampled start.
  task automatic start_job(input logic [AW-1:0] b, input logic [AW:0] l,
                           input logic [SW-1:0] a, input logic [SW-1:0] inc,
                           input logic d);
    @(negedge clk);
    bus.base   = b;
    bus.len    = l;
    bus.amount = a;
    bus.incr   = inc;
    bus.dir    = d;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  // Counts cycles from FETCH entry until done is seen, bounded.
  task automatic wait_done(input string name, input int exp_cycles);
    int  n;
    bit  got;
    n   = 0;
    got = 1'b0;
    while (!got && n < 300) begin
      @(negedge clk);
      n++;
      if (bus.done) got = 1'b1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done after %0d cycles want done", name, n);
    end else begin
      check({name, "_cycles"}, 32'(n), 32'(exp_cycles));
    end
  endtask

  // Bounded wait at negedges for a given state once writes_seen reaches a count.
  task automatic wait_state(input string name, input logic [2:0] st, input int nwr);
    int n;
    n = 0;
    while (!(bus.dbg_state == st && writes_seen == nwr) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got state %0d want %0d", name, bus.dbg_state, st);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    total       = 0;
    bad         = 0;
    done_cnt    = 0;
    writes_seen = 0;
    pl_en       = 1'b0;
    pl_addr     = '0;
    pl_data     = '0;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.base    = '0;
    bus.len     = '0;
    bus.amount  = '0;
    bus.incr    = '0;
    bus.dir     = 1'b0;
    reset       = 1'b1;
    #1 reset    = 1'b0;
    #1;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Single word, rotate left by 1: 0x81 -> 0x03.
    preload(6'd3, 8'h81);
    push_exp(6'd3, 8'h03);
    start_job(6'd3, 7'd1, 3'd1, 3'd0, 1'b0);
`ifdef ROTATE_ENGINE_BARREL_EN
    wait_done("one_word", 4);
`else
    wait_done("one_word", 5);
`endif

    // Three words rotated right by 4, 6, 0.
    preload(6'd0, 8'hA5);
    preload(6'd1, 8'hA5);
    preload(6'd2, 8'hA5);
    push_exp(6'd0, 8'h5A);
    push_exp(6'd1, 8'h96);
    push_exp(6'd2, 8'hA5);
    start_job(6'd0, 7'd3, 3'd4, 3'd2, 1'b1);
`ifdef ROTATE_ENGINE_BARREL_EN
    wait_done("three_right", 12);
`else
    wait_done("three_right", 22);
`endif

    // Address wrap: 62, 63, 0, 1 rotated left by 0..3.
    preload(6'd62, 8'h11);
    preload(6'd63, 8'h22);
    preload(6'd0,  8'h33);
    preload(6'd1,  8'h44);
    push_exp(6'd62, 8'h11);
    push_exp(6'd63, 8'h44);
    push_exp(6'd0,  8'hCC);
    push_exp(6'd1,  8'h22);
    start_job(6'd62, 7'd4, 3'd0, 3'd1, 1'b0);
`ifdef ROTATE_ENGINE_BARREL_EN
    wait_done("wrap", 16);
`else
    wait_done("wrap", 22);
`endif
    @(negedge clk);
    check("wrap_untouched_mem2", 32'(mem[2]), 32'hA5);
    check("wrap_mem0", 32'(mem[0]), 32'hCC);

    // Zero-length job: immediate done, no access, stays idle.
    start_job(6'd5, 7'd0, 3'd3, 3'd1, 1'b0);
    check("len0_done", 32'(bus.done), 32'd1);
    check("len0_ready", 32'(bus.ready), 32'd1);
    check("len0_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    check("len0_done_drop", 32'(bus.done), 32'd0);
    check("len0_state2", 32'(bus.dbg_state), 32'(ST_IDLE));

    // Abort while word 1 of 3 is in progress; only word 0 is written.
    preload(6'd10, 8'h01);
    preload(6'd11, 8'h01);
    preload(6'd12, 8'h01);
    push_exp(6'd10, 8'h04);
    writes_seen = 0;
    start_job(6'd10, 7'd3, 3'd2, 3'd1, 1'b0);
`ifdef ROTATE_ENGINE_BARREL_EN
    wait_state("abort_wait", ST_LOAD, 1);
`else
    wait_state("abort_wait", ST_ROTATE, 1);
`endif
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_no_done", 32'(bus.done), 32'd0);
    repeat (8) @(negedge clk);
    check("abort_writes", 32'(writes_seen), 32'd1);
    check("abort_q_empty", 32'(exp_q.size()), 32'd0);
    // Same parameters again; word 0 now starts from 0x04.
    push_exp(6'd10, 8'h10);
    push_exp(6'd11, 8'h08);
    push_exp(6'd12, 8'h10);
    start_job(6'd10, 7'd3, 3'd2, 3'd1, 1'b0);
`ifdef ROTATE_ENGINE_BARREL_EN
    wait_done("after_abort", 12);
`else
    wait_done("after_abort", 21);
`endif

    // Reset during WRITE of word 0; word 1 must never be written.
    preload(6'd20, 8'h3C);
    preload(6'd21, 8'h77);
    push_exp(6'd20, 8'h3C);
    writes_seen = 0;
    start_job(6'd20, 7'd2, 3'd0, 3'd0, 1'b0);
    wait_state("rst_wait", ST_WRITE, 1);
    reset = 1'b0;
    #1;
    check("midrst_ready", 32'(bus.ready), 32'd1);
    check("midrst_we", 32'(bus.mem_we), 32'd0);
    check("midrst_addr", 32'(bus.mem_addr), 32'd0);
    check("midrst_wdata", 32'(bus.mem_wdata), 32'd0);
    check("midrst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_mem21", 32'(mem[21]), 32'h77);
    check("midrst_writes", 32'(writes_seen), 32'd1);
    // Fresh job after reset: 0x77 rotated right by 1 -> 0xBB.
    push_exp(6'd21, 8'hBB);
    start_job(6'd21, 7'd1, 3'd1, 3'd0, 1'b1);
`ifdef ROTATE_ENGINE_BARREL_EN
    wait_done("fresh", 4);
`else
    wait_done("fresh", 5);
`endif

    // ---------------- final report ----------------
    repeat (3) @(negedge clk);
    check("final_q_empty", 32'(exp_q.size()), 32'd0);
    check("final_done_count", 32'(done_cnt), 32'd6);
    check("final_mem3", 32'(mem[3]), 32'h03);
    check("final_mem21", 32'(mem[21]), 32'hBB);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rotate_engine.md
ROTATE_ENGINE -- requirements
Module: rotate_engine

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits; SHALL be a power of two, 4..64.
REQ-002 Parameter DEPTH, default 64: words in attached memory; SHALL be a power of two, with AW = clog2(DEPTH) and SW = clog2(WIDTH).
REQ-003 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  start request, sampled only in IDLE.
- abort  in  1  cancel job, sampled in every non-IDLE state.
- base  in  AW  first word address, captured at start.
- len  in  AW+1  word count 0..DEPTH, captured at start.
- amount  in  SW  rotate amount for word 0, captured at start.
- incr  in  SW  per-word amount increment, captured at start.
- dir  in  1  0 = rotate left, 1 = rotate right, captured at start.
- mem_addr  out  AW  memory address.
- mem_rdata  in  WIDTH  read data, valid the cycle after address is presented.
- mem_wdata  out  WIDTH  write data.
- mem_we  out  1  write enable, one cycle per word.
- ready  out  1  engine idle, accepts start.
- done  out  1  one-cycle pulse on job completion.

Function
REQ-004 FSM states SHALL be IDLE, FETCH, LOAD, ROTATE, WRITE, NEXT; all outputs SHALL be Moore (decoded from state and registers only).
REQ-005 IDLE: ready=1; start=1 with len>0 SHALL capture the parameters, clear index i and the amount accumulator to amount, and go to FETCH.
REQ-006 start with len=0 SHALL produce no memory access; the FSM stays in IDLE and done=1 on the following cycle.
REQ-007 FETCH SHALL drive mem_addr = (base+i) mod DEPTH (wrap-around required), then go to LOAD.
REQ-008 LOAD SHALL capture mem_rdata into the data register and load the accumulator into the rotate counter; next state SHALL be WRITE if the counter is 0, else ROTATE.
REQ-009 ROTATE SHALL rotate the data register one bit per cycle in direction dir and decrement the counter; it SHALL exit to WRITE in the cycle the counter reaches 0, for exactly r cycles with r = amount for the word.
REQ-010 WRITE SHALL assert mem_we=1 with mem_addr=(base+i) mod DEPTH and mem_wdata = data register, for exactly one cycle.
REQ-011 NEXT SHALL set i=i+1 and accumulator=(accumulator+incr) mod WIDTH; if i+1==len it SHALL go to IDLE with done=1 for one cycle, else go to FETCH.
REQ-012 Word k SHALL therefore be rotated by (amount + k*incr) mod WIDTH; serial throughput SHALL be r+4 cycles per word.
REQ-013 abort=1 in any non-IDLE state SHALL force IDLE next cycle without done; a write already asserted in WRITE that cycle SHALL complete, and no further writes SHALL occur.
REQ-014 start asserted while not in IDLE SHALL be ignored; abort and start both high in IDLE SHALL start the job (abort is ignored in IDLE).
REQ-015 mem_we SHALL be 0 in every state except WRITE; mem_addr and mem_wdata SHALL hold their last value when unused.

Reset
REQ-016 reset low SHALL asynchronously force state IDLE, with ready=1, done=0, mem_we=0, mem_addr=0, mem_wdata=0, and all internal registers 0.
REQ-017 reset asserted mid-job SHALL abandon the job with no further writes; the first start after reset release begins a fresh job.

Configuration
REQ-018 Macro ROTATE_ENGINE_BARREL_EN: when defined, LOAD SHALL capture mem_rdata already rotated by the accumulator amount (single-cycle barrel rotator), ROTATE SHALL never be entered, and throughput SHALL be 4 cycles per word regardless of amount. When undefined, the serial behaviour of REQ-008/009 applies and no barrel logic SHALL be synthesised. Memory results SHALL be identical either way.

Verification
REQ-019 WIDTH=8: mem[3]=0x81; start with base=3, len=1, amount=1, dir=0 -> mem[3]=0x03, done pulses 5 cycles after FETCH entry in serial mode.
REQ-020 mem[0..2]=0xA5; base=0, len=3, amount=4, incr=2, dir=1 -> mem[0]=0x5A, mem[1]=0x96, mem[2]=0xA5 (amount 8 mod 8 = 0, ROTATE skipped).
REQ-021 DEPTH=64: base=62, len=4 -> writes occur at addresses 62, 63, 0, 1 in that order, and at no other address.
REQ-022 start with len=0 -> no mem_we and no FETCH; done=1 exactly one cycle after start; ready stays 1.
REQ-023 abort raised during ROTATE of word 1 of 3 -> only word 0 written, ready=1 next cycle, no done; a second start with identical parameters then completes normally.
REQ-024 reset pulled low during WRITE of word 0 -> all outputs at reset values immediately; no write to word 1.
